// File: rtl/pool_pkg.sv
// Shared types and defaults for the 2x2 / stride-2 max-pooling block.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/pool_row_buf.sv
// Line buffer holding one horizontal pair-maximum per output column between rows.
module pool_row_buf
    import pool_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DEFAULT_DATA_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are fully rewritten on every even row before being read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool_2d.sv
// Streaming 2x2 stride-2 max pooling over a raster-order feature map.
// Define POOL_RELU_EN to clamp negative (two's-complement) samples to zero before pooling.
module max_pool_2d
    import pool_pkg::*;
#(
    parameter int FM_W   = 4,
    parameter int FM_H   = 4,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output pool_state_t       fsm_state
);

    localparam int CW       = $clog2(FM_W);
    localparam int RW       = $clog2(FM_H);
    localparam int LB_DEPTH = FM_W / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam bit W_ODD    = (FM_W % 2) == 1;
    localparam bit H_ODD    = (FM_H % 2) == 1;

    pool_state_t       state, state_next;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              accept, last_col, last_row, pool_en, lbuf_wr;
    logic [DATA_W-1:0] sample, partial, lbuf_rd, cmp_a, max_val;
    logic [AW-1:0]     lbuf_addr;

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready.
    // in_ready is high only in RUN and is withheld on a start cycle so a restart never consumes data.
    assign in_ready  = (state == RUN) && !start;
    assign accept    = in_valid && in_ready;
    assign fsm_state = state;

    assign last_col  = (col == CW'(FM_W - 1));
    assign last_row  = (row == RW'(FM_H - 1));
    assign pool_en   = !(W_ODD && last_col) && !(H_ODD && last_row);
    assign lbuf_addr = AW'(col >> 1);
    assign lbuf_wr   = accept && pool_en && !row[0] && col[0];

`ifdef POOL_RELU_EN
    assign sample = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign sample = in_data;
`endif

    // Odd row, even col merges the stored upper pair; every other compare uses the partial.
    assign cmp_a   = (row[0] && !col[0]) ? lbuf_rd : partial;
    assign max_val = (cmp_a > sample) ? cmp_a : sample;

    pool_row_buf #(
        .DEPTH  (LB_DEPTH),
        .DATA_W (DATA_W)
    ) u_row_buf (
        .clk     (clk),
        .wr_en   (lbuf_wr),
        .wr_addr (lbuf_addr),
        .wr_data (max_val),
        .rd_addr (lbuf_addr),
        .rd_data (lbuf_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (start) begin
                    state_next = RUN;
                end else if (accept && last_col && last_row) begin
                    state_next = DONE;
                end
            end
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            partial   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start) begin
                col  <= '0;
                row  <= '0;
                done <= 1'b0;
            end else if (accept) begin
                col <= last_col ? '0 : col + CW'(1);
                if (last_col) begin
                    row <= last_row ? '0 : row + RW'(1);
                end
                if (pool_en) begin
                    if (!col[0]) begin
                        partial <= row[0] ? max_val : sample;
                    end else if (row[0]) begin
                        out_valid <= 1'b1;
                        out_data  <= max_val;
                    end
                end
                if (last_col && last_row) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2d.sv
// Self-checking bench for max_pool_2d: one 4x4 and one 5x5 instance against a window-max model.
module tb_max_pool_2d;
    import pool_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_a, valid_a, rdy_a, ov_a, done_a;
    logic [DW-1:0] data_a, od_a;
    pool_state_t   st_a;
    logic          start_b, valid_b, rdy_b, ov_b, done_b;
    logic [DW-1:0] data_b, od_b;
    pool_state_t   st_b;

    max_pool_2d #(.FM_W(4), .FM_H(4), .DATA_W(DW)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_data(data_a),
        .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a), .done(done_a), .fsm_state(st_a)
    );

    max_pool_2d #(.FM_W(5), .FM_H(5), .DATA_W(DW)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_data(data_b),
        .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b), .done(done_b), .fsm_state(st_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] frame_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_a[$];
    logic [DW-1:0] obs_b[$];

    always @(negedge clk) begin
        if (ov_a) obs_a.push_back(od_a);
        if (ov_b) obs_b.push_back(od_b);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic v, input logic [DW-1:0] d);
        if (sel == 0) begin
            start_a = st; valid_a = v; data_a = d;
        end else begin
            start_b = st; valid_b = v; data_b = d;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic get_ov(input int sel);
        return (sel == 0) ? ov_a : ov_b;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic logic [1:0] get_state(input int sel);
        return (sel == 0) ? st_a : st_b;
    endfunction

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef POOL_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: each output is the max of its 2x2 block; trailing odd row/col never pooled.
    task automatic build_exp(input int w, input int h);
        exp_q.delete();
        for (int oy = 0; oy < h / 2; oy++) begin
            for (int ox = 0; ox < w / 2; ox++) begin
                logic [DW-1:0] m = '0;
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        logic [DW-1:0] s = relu(frame_q[(2 * oy + dy) * w + 2 * ox + dx]);
                        if (s > m) m = s;
                    end
                end
                exp_q.push_back(m);
            end
        end
    endtask

    task automatic fill_seq(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(DW'(i + 1));
    endtask

    task automatic fill_const(input int n, input logic [DW-1:0] v);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(v);
    endtask

    task automatic fill_rand(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(DW'($urandom_range(0, 255)));
    endtask

    // gap_mode: 0 continuous, 1 one idle cycle between samples, 2 random idle cycles.
    task automatic run_frame(input string tag, input int sel, input int w, input int h, input int gap_mode);
        logic          ready_ok = 1'b1;
        logic [DW-1:0] got[$];
        build_exp(w, h);
        @(posedge clk); #1 drive(sel, 1'b1, 1'b0, '0);
        @(posedge clk); #1 drive(sel, 1'b0, 1'b0, '0);
        if (sel == 0) obs_a.delete(); else obs_b.delete();
        check({tag, "_done_clr"}, get_done(sel), 1'b0);
        check({tag, "_state_run"}, get_state(sel), RUN);
        for (int i = 0; i < w * h; i++) begin
            int idle = 0;
            if (gap_mode == 1 && i > 0) idle = 1;
            if (gap_mode == 2) idle = $urandom_range(0, 2);
            for (int g = 0; g < idle; g++) begin
                drive(sel, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
                @(posedge clk); #1;
            end
            drive(sel, 1'b0, 1'b1, frame_q[i]);
            @(negedge clk);
            if (get_ready(sel) !== 1'b1) ready_ok = 1'b0;
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 1'b0, '0);
        check({tag, "_ready_run"}, ready_ok, 1'b1);
        @(negedge clk);
        check({tag, "_done_rise"}, get_done(sel), 1'b1);
        if (w % 2 == 0 && h % 2 == 0) check({tag, "_final_ov"}, get_ov(sel), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        got = (sel == 0) ? obs_a : obs_b;
        check({tag, "_out_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check({tag, "_out_data"}, got[i], exp_q[i]);
        end
        check({tag, "_done_sticky"}, get_done(sel), 1'b1);
        check({tag, "_state_done"}, get_state(sel), DONE);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ov", ov_a, 1'b0);
        check("rst_od", od_a, '0);
        check("rst_done", done_a, 1'b0);
        check("rst_ready", rdy_a, 1'b0);
        check("rst_state", st_a, IDLE);
        check("rst_ready_b", rdy_b, 1'b0);

        // Samples offered while IDLE must be ignored.
        @(posedge clk); #1 drive(0, 1'b0, 1'b1, 8'hAA);
        repeat (3) @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("idle_ready", rdy_a, 1'b0);
        check("idle_no_out", obs_a.size(), 0);
        check("idle_state", st_a, IDLE);

        fill_seq(16);
        run_frame("seq4", 0, 4, 4, 0);
        fill_seq(25);
        run_frame("seq5", 1, 5, 5, 0);
        fill_seq(16);
        run_frame("gap4", 0, 4, 4, 1);

        // Abort after six large-valued samples, then a full constant frame.
        @(posedge clk); #1 drive(0, 1'b1, 1'b0, '0);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b0, 1'b1, DW'(8'hC0 + i));
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, '0);
        fill_const(16, 8'h10);
        run_frame("abort", 0, 4, 4, 0);

        fill_const(16, 8'hF0);
        run_frame("neg4", 0, 4, 4, 0);
        fill_const(25, 8'hF0);
        run_frame("neg5", 1, 5, 5, 2);

        // Samples offered while DONE must be ignored.
        obs_a.delete();
        @(posedge clk); #1 drive(0, 1'b0, 1'b1, 8'h55);
        repeat (3) @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("done_ready", rdy_a, 1'b0);
        check("done_no_out", obs_a.size(), 0);

        for (int k = 0; k < 3; k++) begin
            fill_rand(16);
            run_frame("rnd4", 0, 4, 4, 2);
            fill_rand(25);
            run_frame("rnd5", 1, 5, 5, 2);
        end

        // Reset mid-frame, asserted together with start and a window-completing sample.
        @(posedge clk); #1 drive(0, 1'b1, 1'b0, '0);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, 1'b1, DW'($urandom_range(0, 255)));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 8'hFF);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("midrst_ov", ov_a, 1'b0);
        check("midrst_done", done_a, 1'b0);
        check("midrst_ready", rdy_a, 1'b0);
        check("midrst_state", st_a, IDLE);
        fill_rand(16);
        run_frame("post_rst", 0, 4, 4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
